// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the digit-serial BCD adder.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam logic [3:0]  BCD_CORRECTION = 4'd6;
    localparam logic [3:0]  BCD_MAX_DIGIT  = 4'd9;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational one-digit BCD adder: 4-bit ripple of full adders plus +6 decimal correction.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   ci,
    output logic [BCD_DIGIT_W-1:0] sum,
    output logic                   co
);

    logic [BCD_DIGIT_W:0]   c;
    logic [BCD_DIGIT_W-1:0] s;
    logic                   gt9;

    assign c[0] = ci;

    for (genvar i = 0; i < BCD_DIGIT_W; i++) begin : g_ripple
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Binary total {c[4], s} exceeds 9 when it overflowed 4 bits or is 10..15.
    always_comb begin
        gt9 = c[BCD_DIGIT_W] | (s[3] & (s[2] | s[1]));
        sum = gt9 ? (s + BCD_CORRECTION) : s;
        co  = gt9;
    end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the ripple element of the digit adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock LSD first, valid/ready on both sides.
// Optional invalid-digit flag 'err' is built only when BCD_INVALID_CHECK_EN is defined.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout
`ifdef BCD_INVALID_CHECK_EN
    ,
    output logic                          err
`endif
);

    localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    logic [1:0]             state;
    logic [1:0]             state_d;
    logic [CNT_W-1:0]       cnt;
    logic [W-1:0]           a_sr;
    logic [W-1:0]           b_sr;
    logic                   carry;
    logic [BCD_DIGIT_W-1:0] dig_sum;
    logic                   dig_co;
    logic                   accept;
    logic                   last_digit;

    // Operand shift regs move right each RUN cycle, so the active digit is always at [3:0].
    bcd_digit_adder u_digit (
        .a   (a_sr[BCD_DIGIT_W-1:0]),
        .b   (b_sr[BCD_DIGIT_W-1:0]),
        .ci  (carry),
        .sum (dig_sum),
        .co  (dig_co)
    );

    always_comb begin
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        accept     = in_ready & in_valid;
        last_digit = (cnt == LAST);
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
        end else if (state == RUN) begin
            sum[cnt*BCD_DIGIT_W +: BCD_DIGIT_W] <= dig_sum;
            carry <= dig_co;
            a_sr  <= a_sr >> BCD_DIGIT_W;
            b_sr  <= b_sr >> BCD_DIGIT_W;
            cnt   <= cnt + 1'b1;
            if (last_digit) begin
                cout <= dig_co;
            end
        end
    end

`ifdef BCD_INVALID_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (state == RUN) begin
            if (digit_invalid(a_sr[BCD_DIGIT_W-1:0]) || digit_invalid(b_sr[BCD_DIGIT_W-1:0])) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule
